instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries; legal values 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_ack  input  1  memory accepts the request and returns data in the same cycle.
REQ-008 imem_rdata  input  32  instruction word; valid when imem_req && imem_ack.
REQ-009 instr  output  32  instruction at buffer head, driven to the CPU instr input.
REQ-010 pc  output  32  address of instr.
REQ-011 instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 instr_ready  input  1  CPU consumes the head this cycle.
REQ-013 redirect  input  1  taken branch or jump; flush and refetch.
REQ-014 redirect_pc  input  32  new fetch address when redirect=1.
REQ-015 fetch_misalign  output  1  sticky trap flag for a redirect target with bits[1:0] != 0.

Function
REQ-016 FSM states: FETCH (imem_req=1), FULL (buffer count == DEPTH, imem_req=0), TRAP (imem_req=0, fetch_misalign=1).
REQ-017 FETCH->FULL when a transfer raises count to DEPTH without a pop; FULL->FETCH when count < DEPTH.
REQ-018 imem_req and imem_addr are registered; imem_addr is held stable while imem_req=1 and imem_ack=0.
REQ-019 Transfer (imem_req && imem_ack): push {fetch_pc, imem_rdata}; fetch_pc += 4 with 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-020 Request issued only while registered count < DEPTH; a push never overflows the buffer.
REQ-021 Pop when instr_valid && instr_ready; push and pop in the same cycle leave count unchanged.
REQ-022 instr_valid = (count != 0); when count == 0, instr = 32'h0000_0013 (NOP) and pc = fetch_pc.
REQ-023 Latency: a transfer in cycle N gives instr_valid=1 with that word in cycle N+1.
REQ-024 Redirect has priority over push and pop: buffer flushed (count=0), a same-cycle transfer discarded, fetch_pc=redirect_pc, state FETCH.
REQ-025 Redirect with redirect_pc[1:0] != 0: flush, state TRAP, fetch_misalign=1; only reset leaves TRAP.
REQ-026 Redirect with instr_ready=1 in the same cycle: the pop is ignored, no double count update.
REQ-027 imem_ack while imem_req=0 is ignored.

Reset
REQ-028 On reset assertion, asynchronously: state=FETCH, fetch_pc=RESET_PC, count=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=NOP, pc=RESET_PC, fetch_misalign=0.
REQ-029 imem_req rises in the first clock edge after reset deasserts; reset mid-transfer drops the pending word.

Structure
REQ-030 Shared package rv32i_pkg holds XLEN=32, NOP_INSTR=32'h0000_0013, PC_STEP=4, and the fetch FSM state enum.
REQ-031 Sub-module instr_fifo: synchronous FIFO, 64-bit entries {pc, instr}, parameterised DEPTH, with flush, count, full and empty outputs.

Verification
REQ-032 Reset release, imem_ack=1, instr_ready=1: instr/pc stream 0x0,0x4,0x8 one per cycle from cycle 2.
REQ-033 instr_ready=0, imem_ack=1: exactly DEPTH words buffered, imem_req=0 (FULL); instr_ready=1 resumes in order.
REQ-034 Redirect to 0x100 while the buffer holds 0x8,0xC and a transfer is in the same cycle: next valid pc=0x100, stale words never appear.
REQ-035 Redirect to 0x102: fetch_misalign=1, imem_req=0, instr_valid=0 until reset.
REQ-036 Redirect to 0xFFFF_FFFC: pcs 0xFFFF_FFFC then 0x0000_0000.
REQ-037 imem_ack held low 3 cycles: imem_addr stable, instr_valid=0, instr=32'h0000_0013.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: datapath width, NOP encoding, PC
// increment, fetch FSM states and the instruction buffer entry layout.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        TRAP  = 2'd2
    } fetch_state_e;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction buffer holding {pc, instr} entries.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   flush_i        drop all entries (wins over push/pop)
//   push_i         write push_data_i at the tail (ignored when full without pop)
//   push_data_i    entry to write
//   pop_i          drop the head entry (ignored when empty)
//   head_o         entry at the head (undefined when empty)
//   count_o        number of stored entries
//   full_o/empty_o occupancy flags
module instr_fifo
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage array; contents are only meaningful below count_q.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory, buffers them
// with their addresses, presents the head to the CPU and handles redirects.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   imem_req/imem_addr    registered fetch request and word address
//   imem_ack/imem_rdata   memory accept and same-cycle instruction data
//   instr/pc/instr_valid  buffer head presented to the CPU (NOP, fetch_pc when empty)
//   instr_ready           CPU consumes the head
//   redirect/redirect_pc  flush and restart fetching at redirect_pc
//   fetch_misalign        sticky flag for a misaligned redirect target
module instr_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            imem_req_q, imem_req_d;
    logic            misalign_q, misalign_d;

    logic            flush_c;
    logic            push_c;
    logic            pop_c;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;
    logic [CNT_W-1:0] count;
    logic            fifo_full;
    logic            fifo_empty;

    assign push_entry.pc    = fetch_pc_q;
    assign push_entry.instr = imem_rdata;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .flush_i     (flush_c),
        .push_i      (push_c),
        .push_data_i (push_entry),
        .pop_i       (pop_c),
        .head_o      (head),
        .count_o     (count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // State and request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            imem_req_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            imem_req_q <= imem_req_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state logic: redirect beats push/pop; TRAP is only left by reset.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        misalign_d = misalign_q;
        flush_c    = 1'b0;
        push_c     = 1'b0;
        pop_c      = 1'b0;

        if (state_q == TRAP) begin
            state_d = TRAP;
        end else if (redirect) begin
            flush_c = 1'b1;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = TRAP;
                misalign_d = 1'b1;
            end else begin
                state_d    = FETCH;
                fetch_pc_d = redirect_pc;
            end
        end else begin
            push_c = imem_req_q && imem_ack;
            pop_c  = instr_valid && instr_ready;
            if (push_c) fetch_pc_d = fetch_pc_q + PC_STEP;
            // Buffer is full next cycle if it stays full, or the last free slot fills without a pop.
            if ((fifo_full && !pop_c) ||
                ((count == CNT_W'(DEPTH - 1)) && push_c && !pop_c)) begin
                state_d = FULL;
            end else begin
                state_d = FETCH;
            end
        end
    end

    // A request is registered only for cycles in which the buffer has room.
    assign imem_req_d = (state_d == FETCH);

    assign imem_req       = imem_req_q;
    assign imem_addr      = fetch_pc_q;
    assign fetch_misalign = misalign_q;
    assign instr_valid    = !fifo_empty;
    assign instr          = fifo_empty ? NOP_INSTR  : head.instr;
    assign pc             = fifo_empty ? fetch_pc_q : head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (DEPTH=4). The memory returns ~addr as data.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .pc             (pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one cycle; memory data follows the registered address.
    task automatic tick();
        @(posedge clk);
        #1;
        imem_rdata = ~imem_addr;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, instr, 32'h0000_0013);
    endtask

    task automatic check_head(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_instr"}, instr, exp_instr);
    endtask

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();

        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_mis", 32'(fetch_misalign), 32'd0);
        check_empty("rst");

        // Streaming from reset: one word per cycle from cycle 2.
        reset       = 1'b0;
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        tick();
        check("c1_req", 32'(imem_req), 32'd1);
        check("c1_addr", imem_addr, 32'h0);
        check_empty("c1");
        tick();
        check_head("c2", 32'h0000_0000, 32'hFFFF_FFFF);
        tick();
        check_head("c3", 32'h0000_0004, 32'hFFFF_FFFB);
        tick();
        check_head("c4", 32'h0000_0008, 32'hFFFF_FFF7);

        // Buffer 0x8,0xC then redirect while 0x10 transfers.
        instr_ready = 1'b0;
        tick();
        check_head("c5", 32'h0000_0008, 32'hFFFF_FFF7);
        check("c5_req", 32'(imem_req), 32'd1);
        check("c5_addr", imem_addr, 32'h0000_0010);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        check_empty("rd1");
        check("rd1_pc", pc, 32'h0000_0100);
        check("rd1_addr", imem_addr, 32'h0000_0100);
        check("rd1_req", 32'(imem_req), 32'd1);
        tick();
        check_head("rd2", 32'h0000_0100, 32'hFFFF_FEFF);
        tick();
        check_head("rd3", 32'h0000_0104, 32'hFFFF_FEFB);

        // Stall the CPU until the buffer fills.
        instr_ready = 1'b0;
        tick();
        tick();
        tick();
        check("full1_req", 32'(imem_req), 32'd0);
        check("full1_addr", imem_addr, 32'h0000_0114);
        check_head("full1", 32'h0000_0104, 32'hFFFF_FEFB);
        tick();
        check("full2_req", 32'(imem_req), 32'd0);
        check("full2_addr", imem_addr, 32'h0000_0114);
        check_head("full2", 32'h0000_0104, 32'hFFFF_FEFB);

        // Resume: remaining words drain in order, fetching restarts.
        instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_head("drain", 32'h0000_0108 + 32'(4 * k), ~(32'h0000_0108 + 32'(4 * k)));
            if (k == 0) check("drain_req", 32'(imem_req), 32'd1);
        end

        // Memory stalls for three cycles after a redirect.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        imem_ack    = 1'b0;
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_addr", imem_addr, 32'h0000_0200);
            check("stall_req", 32'(imem_req), 32'd1);
            check_empty("stall");
            if (k < 2) tick();
        end
        imem_ack = 1'b1;
        tick();
        check_head("stall_end", 32'h0000_0200, 32'hFFFF_FDFF);

        // Address wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check_empty("wrap0");
        check("wrap0_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check_head("wrap1", 32'hFFFF_FFFC, 32'h0000_0003);
        check("wrap1_addr", imem_addr, 32'h0000_0000);
        tick();
        check_head("wrap2", 32'h0000_0000, 32'hFFFF_FFFF);

        // Misaligned redirect traps; a later aligned redirect cannot leave TRAP.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        tick();
        redirect = 1'b0;
        check("trap1_mis", 32'(fetch_misalign), 32'd1);
        check("trap1_req", 32'(imem_req), 32'd0);
        check_empty("trap1");
        tick();
        tick();
        check("trap2_mis", 32'(fetch_misalign), 32'd1);
        check("trap2_req", 32'(imem_req), 32'd0);
        check_empty("trap2");
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect = 1'b0;
        check("trap3_mis", 32'(fetch_misalign), 32'd1);
        check("trap3_req", 32'(imem_req), 32'd0);
        tick();
        check_empty("trap4");

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b1;
        #1;
        check("arst_mis", 32'(fetch_misalign), 32'd0);
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_pc", pc, 32'h0);
        check_empty("arst");
        tick();
        reset = 1'b0;
        tick();
        check("rel_req", 32'(imem_req), 32'd1);
        check("rel_addr", imem_addr, 32'h0);
        tick();
        check_head("rel", 32'h0000_0000, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
